// File: rtl/phy_clk_gate_ctrl.sv
// Clock-enable controller for the PHY latch-based clock gate: OFF/WAKE/ON/IDLE FSM
// with wake settle and idle hysteresis. Define PHY_CLK_GATE_CTRL_REQ_SYNC_EN to synchronise req.

`ifdef PHY_CLK_GATE_CTRL_REQ_SYNC_EN
module phy_clk_gate_ctrl_sync (
  input  logic i_clk_in,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule
`endif

module phy_clk_gate_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic               i_clk_in,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_force_on,
  input  logic [IDLE_W-1:0]  i_idle_limit,
  output logic               o_clk_en,
  output logic               o_ack,
  output logic [1:0]         o_gate_state
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  localparam logic [3:0]        WAKE_LD  = 4'(WAKE_CYC);
  localparam logic [3:0]        WAKE_ONE = 4'd1;
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  if (WAKE_CYC < 1 || WAKE_CYC > 15) begin : g_bad_wake
    $error("phy_clk_gate_ctrl: WAKE_CYC must be 1..15");
  end

  logic [NUM_REQ-1:0] w_req;
  logic               w_any_req;

`ifdef PHY_CLK_GATE_CTRL_REQ_SYNC_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
    phy_clk_gate_ctrl_sync u_sync (
      .i_clk_in (i_clk_in),
      .i_reset  (i_reset),
      .i_d      (i_req[g]),
      .o_q      (w_req[g])
    );
  end
`else
  assign w_req = i_req;
`endif

  // force_on bypasses the synchroniser: it is a quasi-static software control
  assign w_any_req = (|w_req) | i_force_on;

  state_e            r_state;
  state_e            w_nxt_state;
  logic [3:0]        r_wake_cnt;
  logic [3:0]        w_nxt_wake_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_nxt_idle_cnt;
  logic              r_clk_en;
  logic              r_ack;
  logic              w_nxt_clk_en;
  logic              w_nxt_ack;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_wake_cnt = r_wake_cnt;
    w_nxt_idle_cnt = r_idle_cnt;
    unique case (r_state)
      ST_OFF: begin
        if (w_any_req) begin
          w_nxt_state    = ST_WAKE;
          w_nxt_wake_cnt = WAKE_LD;
        end
      end
      ST_WAKE: begin
        // settle period always runs to completion, even if requests drop
        if (r_wake_cnt <= WAKE_ONE) w_nxt_state    = ST_ON;
        else                        w_nxt_wake_cnt = r_wake_cnt - WAKE_ONE;
      end
      ST_ON: begin
        if (!w_any_req) begin
          if (i_idle_limit != '0) begin
            w_nxt_state    = ST_IDLE;
            w_nxt_idle_cnt = i_idle_limit;
          end else begin
            w_nxt_state    = ST_OFF;
          end
        end
      end
      ST_IDLE: begin
        // a request on the final idle cycle wins, so clk_en never glitches low
        if (w_any_req)                   w_nxt_state    = ST_ON;
        else if (r_idle_cnt <= IDLE_ONE) w_nxt_state    = ST_OFF;
        else                             w_nxt_idle_cnt = r_idle_cnt - IDLE_ONE;
      end
      default: w_nxt_state = ST_OFF;
    endcase
  end

  assign w_nxt_clk_en = (w_nxt_state != ST_OFF);
  assign w_nxt_ack    = (w_nxt_state == ST_ON) || (w_nxt_state == ST_IDLE);

  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_state    <= ST_OFF;
      r_wake_cnt <= '0;
      r_idle_cnt <= '0;
      r_clk_en   <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_wake_cnt <= w_nxt_wake_cnt;
      r_idle_cnt <= w_nxt_idle_cnt;
      r_clk_en   <= w_nxt_clk_en;
      r_ack      <= w_nxt_ack;
    end
  end

  assign o_clk_en     = r_clk_en;
  assign o_ack        = r_ack;
  assign o_gate_state = r_state;

endmodule
